// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - operation select encoding driven on OpE
//   - FSM state encoding
//   - number of radix-2 iterations per operation
package muldiv_pkg;

    localparam logic [1:0] OP_UMULL = 2'b00;
    localparam logic [1:0] OP_SMULL = 2'b01;
    localparam logic [1:0] OP_UDIV  = 2'b10;
    localparam logic [1:0] OP_SDIV  = 2'b11;

    localparam int unsigned MULDIV_ITER = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / 32/32 divide for the Execute stage.
// One radix-2 step per cycle on operand magnitudes, followed by a sign-fix cycle.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   MulOpE      start request (accepted only in idle)
//   OpE         00 UMULL, 01 SMULL, 10 UDIV, 11 SDIV
//   SrcAE       multiplicand / dividend
//   SrcBE       multiplier / divisor
//   FlushE      synchronous abort, wins over MulOpE
//   BusyE       stall request (high while iterating or fixing signs)
//   DoneE       one-cycle result-valid pulse
//   ResultLoE   product[31:0] or quotient
//   ResultHiE   product[63:32] or remainder
//   DivByZeroE  divide-by-zero flag, qualified by DoneE
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MulOpE,
    input  logic [1:0]  OpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        FlushE,
    output logic        BusyE,
    output logic        DoneE,
    output logic [31:0] ResultLoE,
    output logic [31:0] ResultHiE,
    output logic        DivByZeroE
);

    localparam logic [4:0] IterLast = 5'(MULDIV_ITER - 1);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dbz_q, dbz_d;
    // {acc/remainder[32:0], multiplier/quotient[31:0]}
    logic [64:0] acc_q, acc_d;
    logic [32:0] opb_q, opb_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] res_hi_q, res_hi_d;

    // Operand decode and 33-bit magnitudes (|-2^31| fits exactly)
    logic        in_div, in_signed;
    logic [32:0] a_ext, b_ext, a_mag, b_mag;

    assign in_div    = (OpE == OP_UDIV) || (OpE == OP_SDIV);
    assign in_signed = (OpE == OP_SMULL) || (OpE == OP_SDIV);
    assign a_ext     = {in_signed & SrcAE[31], SrcAE};
    assign b_ext     = {in_signed & SrcBE[31], SrcBE};
    assign a_mag     = a_ext[32] ? -a_ext : a_ext;
    assign b_mag     = b_ext[32] ? -b_ext : b_ext;

    // Shift-add multiply step: add multiplicand when current multiplier bit is set,
    // then shift the whole accumulator/multiplier pair right.
    logic [32:0] mul_sum;
    logic [64:0] mul_next;
    assign mul_sum  = acc_q[64:32] + (acc_q[0] ? opb_q : 33'd0);
    assign mul_next = {1'b0, mul_sum, acc_q[31:1]};

    // Restoring divide step on the left-shifted remainder/quotient pair.
    logic [32:0] div_rem_sh;
    logic [30:0] div_quo_sh;
    logic [33:0] div_diff;
    logic [64:0] div_next;
    assign div_rem_sh = acc_q[63:31];
    assign div_quo_sh = acc_q[30:0];
    assign div_diff   = {1'b0, div_rem_sh} - {1'b0, opb_q};
    assign div_next   = div_diff[33] ? {div_rem_sh, div_quo_sh, 1'b0}
                                     : {div_diff[32:0], div_quo_sh, 1'b1};

    // Sign correction applied in the fix state
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    assign prod_fix = neg_res_q ? -acc_q[63:0] : acc_q[63:0];
    assign quo_fix  = neg_res_q ? -acc_q[31:0] : acc_q[31:0];
    assign rem_fix  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;

        unique case (state_q)
            StIdle: begin
                if (MulOpE) begin
                    is_div_d  = in_div;
                    cnt_d     = '0;
                    neg_res_d = in_signed & (SrcAE[31] ^ SrcBE[31]);
                    neg_rem_d = in_signed & SrcAE[31];
                    opb_d     = b_mag;
                    if (in_div && (SrcBE == '0)) begin
                        // Keep the raw dividend so it can be returned as the remainder
                        dbz_d   = 1'b1;
                        acc_d   = {33'd0, SrcAE};
                        state_d = StFix;
                    end else begin
                        dbz_d   = 1'b0;
                        acc_d   = {32'd0, a_mag};
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == IterLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (dbz_q) begin
                    res_lo_d = '0;
                    res_hi_d = acc_q[31:0];
                end else if (is_div_q) begin
                    res_lo_d = quo_fix;
                    res_hi_d = rem_fix;
                end else begin
                    res_lo_d = prod_fix[31:0];
                    res_hi_d = prod_fix[63:32];
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort leaves the previously completed result untouched
        if (FlushE) begin
            state_d  = StIdle;
            res_lo_d = res_lo_q;
            res_hi_d = res_hi_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            acc_q     <= '0;
            opb_q     <= '0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            res_lo_q  <= res_lo_d;
            res_hi_q  <= res_hi_d;
        end
    end

    assign BusyE      = (state_q == StRun) || (state_q == StFix);
    assign DoneE      = (state_q == StDone);
    assign DivByZeroE = DoneE & dbz_q;
    assign ResultLoE  = res_lo_q;
    assign ResultHiE  = res_hi_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Expected results come from
// plain 64-bit arithmetic on the operands; timing expectations from the cycle counts
// of the protocol (33 busy cycles, done after the 33rd edge, or after 1 edge on /0).
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        MulOpE;
    logic [1:0]  OpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        FlushE;
    logic        BusyE;
    logic        DoneE;
    logic [31:0] ResultLoE;
    logic [31:0] ResultHiE;
    logic        DivByZeroE;

    muldiv_unit dut (
        .clk        (clk),
        .reset      (reset),
        .MulOpE     (MulOpE),
        .OpE        (OpE),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .FlushE     (FlushE),
        .BusyE      (BusyE),
        .DoneE      (DoneE),
        .ResultLoE  (ResultLoE),
        .ResultHiE  (ResultHiE),
        .DivByZeroE (DivByZeroE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outcome of the operation in flight and of the last completed one
    logic [31:0] exp_lo, exp_hi;
    logic        exp_dbz;
    int          exp_lat;
    int          busy_cnt;
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: returns {dbz, hi, lo}
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b0, p};
            end
            2'b01: begin
                p = 64'(sa * sb);
                return {1'b0, p};
            end
            2'b10: begin
                if (b == 0) return {1'b1, a, 32'd0};
                return {1'b0, a % b, a / b};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'd0};
                sq = sa / sb;
                sr = sa % sb;
                return {1'b0, sr[31:0], sq[31:0]};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Drive a start and let it be taken on the next rising edge (T0)
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [64:0] m;
        m       = model(op, a, b);
        exp_dbz = m[64];
        exp_hi  = m[63:32];
        exp_lo  = m[31:0];
        exp_lat = (op[1] && b == 0) ? 1 : 33;
        OpE     = op;
        SrcAE   = a;
        SrcBE   = b;
        MulOpE  = 1'b1;
        @(posedge clk);
        #1;
        MulOpE   = 1'b0;
        busy_cnt = BusyE ? 1 : 0;
    endtask

    // Wait for DoneE (bounded), optionally pulsing MulOpE after inject_at edges
    task automatic finish_op(input string tag, input int inject_at);
        int lat;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            if (i == inject_at) begin
                MulOpE = 1'b1;
                OpE    = 2'($urandom);
                SrcAE  = $urandom;
                SrcBE  = $urandom;
            end
            @(posedge clk);
            #1;
            MulOpE = 1'b0;
            if (DoneE) begin
                lat = i;
                break;
            end
            if (BusyE) busy_cnt++;
        end
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, " busy"}, 64'(busy_cnt), 64'(exp_lat));
        check_eq({tag, " lo"}, 64'(ResultLoE), 64'(exp_lo));
        check_eq({tag, " hi"}, 64'(ResultHiE), 64'(exp_hi));
        check_eq({tag, " dbz"}, 64'(DivByZeroE), 64'(exp_dbz));
        @(posedge clk);
        #1;
        check_eq({tag, " done pulse"}, 64'(DoneE), 64'd0);
        check_eq({tag, " dbz after"}, 64'(DivByZeroE), 64'd0);
        check_eq({tag, " hold"}, {ResultHiE, ResultLoE}, {exp_hi, exp_lo});
        last_lo = exp_lo;
        last_hi = exp_hi;
    endtask

    initial begin
        reset  = 1'b0;
        MulOpE = 1'b0;
        OpE    = 2'b00;
        SrcAE  = '0;
        SrcBE  = '0;
        FlushE = 1'b0;
        #1;
        check_eq("reset outputs", {BusyE, DoneE, DivByZeroE, ResultHiE, ResultLoE}, 67'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases (first start on the first edge after reset release)
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("umull max", 0);
        start_op(2'b01, 32'hFFFF_FFFE, 32'h0000_0003);
        finish_op("smull ignore start", 5);
        start_op(2'b10, 32'd100, 32'd7);
        finish_op("udiv 100/7", 0);
        start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
        finish_op("sdiv -7/2", 0);
        start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("sdiv overflow", 0);
        start_op(2'b10, 32'd5, 32'd0);
        finish_op("udiv by zero", 0);
        start_op(2'b11, 32'hFFFF_FFF0, 32'd0);
        finish_op("sdiv by zero", 0);

        // Flush mid-multiply: busy drops, no done, old results kept
        start_op(2'b00, $urandom, $urandom);
        for (int i = 1; i < 10; i++) @(posedge clk);
        #1;
        FlushE = 1'b1;
        @(posedge clk);
        #1;
        FlushE = 1'b0;
        check_eq("flush busy", 64'(BusyE), 64'd0);
        check_eq("flush done", 64'(DoneE), 64'd0);
        check_eq("flush retain", {ResultHiE, ResultLoE}, {last_hi, last_lo});
        start_op(2'b01, 32'h8000_0000, 32'h8000_0000);
        finish_op("after flush", 0);

        // Asynchronous reset mid-operation
        start_op(2'b11, $urandom, 32'd3);
        for (int i = 1; i < 20; i++) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async reset", {BusyE, DoneE, DivByZeroE, ResultHiE, ResultLoE}, 67'd0);
        @(negedge clk);
        reset   = 1'b1;
        last_lo = '0;
        last_hi = '0;
        start_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        finish_op("after reset", 0);

        // Randomized operations, divisor occasionally forced to zero
        for (int k = 0; k < 40; k++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = pick_val();
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_val();
            start_op(op, a, b);
            finish_op("random", 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL provide port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL provide port MulOpE, input, 1 bit: start request from the controller in the Execute stage.
REQ-004 SHALL provide port OpE, input, 2 bits: operation select. 00 UMULL, 01 SMULL, 10 UDIV, 11 SDIV.
REQ-005 SHALL provide ports SrcAE and SrcBE, input, 32 bits each: multiplicand/dividend (A) and multiplier/divisor (B).
REQ-006 SHALL provide port FlushE, input, 1 bit: synchronous abort.
REQ-007 SHALL provide port BusyE, output, 1 bit: stall request to the hazard logic.
REQ-008 SHALL provide port DoneE, output, 1 bit: one-cycle result-valid pulse.
REQ-009 SHALL provide port ResultLoE, output, 32 bits: product[31:0] for multiplies, quotient for divides.
REQ-010 SHALL provide port ResultHiE, output, 32 bits: product[63:32] for multiplies, remainder for divides.
REQ-011 SHALL provide port DivByZeroE, output, 1 bit: flag, valid while DoneE is high.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIX and DONE.
REQ-013 IDLE with MulOpE=1 and FlushE=0 SHALL latch OpE and the operand magnitudes, clear the iteration counter, and go to RUN.
REQ-014 MulOpE SHALL be ignored in RUN, FIX and DONE; there is no queueing.
REQ-015 RUN SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring subtract for divide.
REQ-016 RUN SHALL last exactly 32 cycles (counter 0..31) and then go to FIX.
REQ-017 FIX SHALL apply sign correction for signed ops:
- product negated if A[31]^B[31];
- quotient negated if A[31]^B[31];
- remainder takes the sign of the dividend.
REQ-018 FIX SHALL then go to DONE.
REQ-019 DONE SHALL assert DoneE for exactly one cycle with results valid, then go to IDLE.
REQ-020 With a start accepted at edge T0, DoneE SHALL be high in cycle T0+34.
REQ-021 BusyE SHALL be high in RUN and FIX, and low in IDLE and DONE.
REQ-022 The result registers SHALL hold the last completed result until the next DONE.
REQ-023 A divide with SrcBE=0 SHALL skip RUN: IDLE→FIX→DONE, with DoneE at T0+2.
REQ-024 A divide by zero SHALL give ResultLoE=0, ResultHiE=dividend and DivByZeroE=1.
REQ-025 DivByZeroE SHALL be 0 for all other operations.
REQ-026 SDIV 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-027 Signed magnitude handling SHALL use 33-bit internal width so that |−2^31| is represented exactly.
REQ-028 FlushE=1 in any state SHALL force IDLE on the next edge, with DoneE=0 and the result registers unchanged.
REQ-029 FlushE SHALL take priority over MulOpE.

Reset
REQ-030 Asserting reset (low) SHALL immediately force IDLE, including mid-operation.
REQ-031 Reset SHALL set BusyE=0, DoneE=0, DivByZeroE=0, ResultLoE=0, ResultHiE=0 and the counter to 0.
REQ-032 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-033 Shared package muldiv_pkg SHALL hold:
- the op encoding constants (OP_UMULL, OP_SMULL, OP_UDIV, OP_SDIV);
- the FSM state encoding;
- the constant MULDIV_ITER=32.
REQ-034 The block SHALL be a single module with no sub-module.
REQ-035 The datapath SHALL be one 65-bit shift register holding accumulator/remainder plus multiplier/quotient, plus a 33-bit operand register.

Verification
REQ-036 UMULL 0xFFFFFFFF×0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001, DoneE at T0+34, BusyE high for 33 cycles.
REQ-037 SMULL 0xFFFFFFFE×0x00000003 → Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; a MulOpE pulse at T0+5 is ignored.
REQ-038 UDIV 100/7 → Lo=14, Hi=2; SDIV 0xFFFFFFF9/2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; SDIV 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0.
REQ-039 UDIV 5/0 → DoneE at T0+2, Lo=0, Hi=5, DivByZeroE=1.
REQ-040 FlushE at T0+10 of a multiply → BusyE=0 at T0+11, no DoneE, previous results retained; a new start at T0+11 completes normally.
REQ-041 reset low at T0+20 → all outputs 0 immediately; a start after release gives a correct result.
